// File: rtl/whack_round_ctrl.sv
// whack_round_ctrl: round sequencer for the hit-or-miss reaction game.
// Issues a one-cycle freq pulse and a one-hot LED target per round, times the
// response window, judges hit/miss and tracks score, lives and round count.
//
// Optional feature macro: WHACK_SPEEDUP_EN (each hit shrinks the response
// window by 1/8, floored at MIN_WINDOW). Undefined: window fixed at WINDOW_CYCLES.
//
// Ports:
//   clk_i         clock
//   rst_i         asynchronous active-high reset
//   start_i       start/restart pulse, honoured in IDLE or DONE only
//   random_i[7:0] free-running random value, bits [2:0] select the target LED
//   hit_i, miss_i response flags from the hit detector
//   freq_o        one-cycle round-start pulse
//   led_o[7:0]    one-hot target LED, 0 outside an active round
//   score_o[7:0]  hits this game (saturating)
//   lives_o[3:0]  remaining lives
//   round_idx_o   rounds resolved this game
//   busy_o        high in GAP, ARM and WAIT
//   game_over_o   high in DONE
//
// state | meaning
// IDLE  | after reset, waiting for start
// GAP   | idle pause between rounds
// ARM   | one cycle: freq pulse, target LED latched
// WAIT  | response window running
// DONE  | game over, score/lives held
module whack_round_ctrl #(
    parameter int unsigned GAP_CYCLES    = 50_000_000,
    parameter int unsigned WINDOW_CYCLES = 100_000_000,
    parameter int unsigned BLANK_CYCLES  = 2,
    parameter int unsigned ROUNDS        = 16,
    parameter int unsigned LIVES         = 3,
    parameter int unsigned MIN_WINDOW    = 10_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] random_i,
    input  logic       hit_i,
    input  logic       miss_i,
    output logic       freq_o,
    output logic [7:0] led_o,
    output logic [7:0] score_o,
    output logic [3:0] lives_o,
    output logic [7:0] round_idx_o,
    output logic       busy_o,
    output logic       game_over_o
);

    typedef enum logic [2:0] {S_IDLE, S_GAP, S_ARM, S_WAIT, S_DONE} state_t;

    state_t      state_q;
    logic [31:0] cnt_q;
    logic [31:0] win_q;
    logic        freq_q;
    logic        busy_q;
    logic        over_q;
    logic [7:0]  led_q;
    logic [7:0]  score_q;
    logic [7:0]  round_q;
    logic [3:0]  lives_q;

    logic        sample_en;
    logic        got_hit;
    logic        got_miss;
    logic        resolve;
    logic [7:0]  score_d;
    logic [7:0]  round_d;
    logic [3:0]  lives_d;
    logic [31:0] win_d;

    // hit/miss are blanked for the first BLANK_CYCLES of the window; a hit
    // takes priority over a simultaneous miss or the timeout.
    assign sample_en = (state_q == S_WAIT) && (cnt_q >= 32'(BLANK_CYCLES));
    assign got_hit   = sample_en && hit_i;
    assign got_miss  = (state_q == S_WAIT) && !got_hit &&
                       ((sample_en && miss_i) || (cnt_q == win_q - 32'd1));
    assign resolve   = got_hit || got_miss;

    assign score_d = (got_hit && score_q != 8'hFF) ? score_q + 8'd1 : score_q;
    assign lives_d = got_miss ? lives_q - 4'd1 : lives_q;
    assign round_d = round_q + 8'd1;

`ifdef WHACK_SPEEDUP_EN
    logic [31:0] win_dec;
    assign win_dec = win_q - (win_q >> 3);
    assign win_d   = !got_hit ? win_q :
                     (win_dec < 32'(MIN_WINDOW)) ? 32'(MIN_WINDOW) : win_dec;
    logic unused_random;
    assign unused_random = ^random_i[7:3];
`else
    assign win_d = win_q;
    logic unused_random;
    assign unused_random = ^{random_i[7:3], 32'(MIN_WINDOW)};
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            win_q   <= 32'(WINDOW_CYCLES);
            freq_q  <= 1'b0;
            busy_q  <= 1'b0;
            over_q  <= 1'b0;
            led_q   <= '0;
            score_q <= '0;
            round_q <= '0;
            lives_q <= '0;
        end else begin
            freq_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        score_q <= '0;
                        round_q <= '0;
                        lives_q <= 4'(LIVES);
                        win_q   <= 32'(WINDOW_CYCLES);
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        over_q  <= 1'b0;
                        state_q <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (cnt_q == 32'(GAP_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        freq_q  <= 1'b1;
                        led_q   <= 8'd1 << random_i[2:0];
                        state_q <= S_ARM;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                S_ARM: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (resolve) begin
                        led_q   <= '0;
                        score_q <= score_d;
                        lives_q <= lives_d;
                        round_q <= round_d;
                        win_q   <= win_d;
                        cnt_q   <= '0;
                        if (lives_d == 4'd0 || round_d == 8'(ROUNDS)) begin
                            busy_q  <= 1'b0;
                            over_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_GAP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign freq_o      = freq_q;
    assign led_o       = led_q;
    assign score_o     = score_q;
    assign lives_o     = lives_q;
    assign round_idx_o = round_q;
    assign busy_o      = busy_q;
    assign game_over_o = over_q;

endmodule

// File: tb/tb_whack_round_ctrl.sv
module tb_whack_round_ctrl;

    localparam int GAP    = 4;
    localparam int WIN    = 10;
    localparam int BLANK  = 2;
    localparam int ROUNDS = 3;
    localparam int LIVES  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic [7:0] random = 8'h00;
    logic       freq;
    logic [7:0] led;
    logic [7:0] score;
    logic [3:0] lives;
    logic [7:0] round_idx;
    logic       busy;
    logic       game_over;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] score;
        logic [3:0] lives;
        logic [7:0] rnd;
    } res_t;

    res_t       exp_q[$];
    res_t       mon_exp;
    logic [7:0] prev_round = 8'h00;
    logic [7:0] m_score;
    logic [3:0] m_lives;
    logic [7:0] m_round;

    always #5 clk = ~clk;

    whack_round_ctrl #(
        .GAP_CYCLES(GAP), .WINDOW_CYCLES(WIN), .BLANK_CYCLES(BLANK),
        .ROUNDS(ROUNDS), .LIVES(LIVES), .MIN_WINDOW(WIN)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .random_i(random),
        .hit_i(hit), .miss_i(miss), .freq_o(freq), .led_o(led),
        .score_o(score), .lives_o(lives), .round_idx_o(round_idx),
        .busy_o(busy), .game_over_o(game_over)
    );

    // Scoreboard: every round resolution is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && round_idx == prev_round + 8'd1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: resolution seen round_idx=%0d, none expected", round_idx);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({score, lives, round_idx, led} !== {mon_exp.score, mon_exp.lives, mon_exp.rnd, 8'h00}) begin
                    errors++;
                    $display("FAIL sb_resolution: got score=%0d lives=%0d round=%0d led=%h, want score=%0d lives=%0d round=%0d led=00",
                             score, lives, round_idx, led, mon_exp.score, mon_exp.lives, mon_exp.rnd);
                end
            end
        end
        prev_round = round_idx;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input bit was_hit);
        res_t e;
        if (was_hit) begin
            if (m_score != 8'hFF) m_score = m_score + 8'd1;
        end else begin
            m_lives = m_lives - 4'd1;
        end
        m_round = m_round + 8'd1;
        e.score = m_score;
        e.lives = m_lives;
        e.rnd   = m_round;
        exp_q.push_back(e);
    endtask

    task automatic new_game(input logic [7:0] rnd_val);
        random  = rnd_val;
        start   = 1'b1;
        m_score = 8'd0;
        m_lives = 4'(LIVES);
        m_round = 8'd0;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_arm(input string tag);
        int n = 0;
        while (freq !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (freq !== 1'b1) begin
            errors++;
            $display("FAIL %s_arm_timeout: freq=%b after %0d cycles, want 1", tag, freq, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({freq, led, score, lives, round_idx, busy, game_over} !== 31'd0) begin
            errors++;
            $display("FAIL reset_outputs: freq=%b led=%h score=%0d lives=%0d round=%0d busy=%b over=%b, want all 0",
                     freq, led, score, lives, round_idx, busy, game_over);
        end
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || freq !== 1'b0 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: busy=%b freq=%b over=%b, want 0 0 0", busy, freq, game_over);
        end
    endtask

    task automatic test_start_timing();
        new_game(8'h05);
        for (int c = 1; c <= GAP; c++) begin
            checks++;
            if (busy !== 1'b1 || freq !== 1'b0 || led !== 8'h00) begin
                errors++;
                $display("FAIL gap_cycle%0d: busy=%b freq=%b led=%h, want busy=1 freq=0 led=00", c, busy, freq, led);
            end
            tick();
        end
        checks++;
        if (freq !== 1'b1 || led !== 8'h20) begin
            errors++;
            $display("FAIL arm_cycle: freq=%b led=%h, want freq=1 led=20", freq, led);
        end
        tick();
        checks++;
        if (freq !== 1'b0 || led !== 8'h20 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_first: freq=%b led=%h busy=%b, want freq=0 led=20 busy=1", freq, led, busy);
        end
    endtask

    // Entered in the first WAIT cycle of round 1.
    task automatic test_blank_hit();
        hit = 1'b1;
        tick();
        hit = 1'b0;
        checks++;
        if (score !== 8'd0 || led !== 8'h20 || round_idx !== 8'd0) begin
            errors++;
            $display("FAIL blank_hit_ignored: score=%0d led=%h round=%0d, want 0 20 0", score, led, round_idx);
        end
        tick();
        hit = 1'b1;
        push_exp(1'b1);
        tick();
        hit = 1'b0;
        checks++;
        if (led !== 8'h00 || score !== 8'd1 || lives !== 4'd2 || busy !== 1'b1 || freq !== 1'b0) begin
            errors++;
            $display("FAIL hit_resolve: led=%h score=%0d lives=%0d busy=%b freq=%b, want 00 1 2 1 0",
                     led, score, lives, busy, freq);
        end
    endtask

    task automatic test_reset_mid_wait();
        int bad = 0;
        wait_arm("midwait");
        tick();
        tick();
        rst = 1'b1;
        #2;
        checks++;
        if ({led, score, round_idx, lives, busy, game_over, freq} !== 31'd0) begin
            errors++;
            $display("FAIL reset_mid_wait: led=%h score=%0d round=%0d lives=%0d busy=%b over=%b freq=%b, want all 0",
                     led, score, round_idx, lives, busy, game_over, freq);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (freq !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL post_reset_quiet: %0d cycles with freq/busy high, want 0", bad);
        end
    endtask

    task automatic test_timeout();
        int n;
        new_game(8'h02);
        for (int r = 1; r <= 2; r++) begin
            wait_arm("timeout");
            checks++;
            if (led !== 8'h04) begin
                errors++;
                $display("FAIL timeout_led_r%0d: led=%h, want 04", r, led);
            end
            push_exp(1'b0);
            n = 0;
            tick();
            while (led !== 8'h00 && n < 40) begin
                n++;
                tick();
            end
            checks++;
            if (n != WIN || lives !== 4'(LIVES - r)) begin
                errors++;
                $display("FAIL timeout_r%0d: wait_cycles=%0d lives=%0d, want %0d %0d", r, n, lives, WIN, LIVES - r);
            end
        end
        checks++;
        if (game_over !== 1'b1 || busy !== 1'b0 || round_idx !== 8'd2 || lives !== 4'd0) begin
            errors++;
            $display("FAIL out_of_lives: over=%b busy=%b round=%0d lives=%0d, want 1 0 2 0",
                     game_over, busy, round_idx, lives);
        end
    endtask

    // Restart from DONE, then three hits at WAIT cycles 3, 6 and 10 (last cycle).
    task automatic test_hit_and_miss();
        int hit_at[3] = '{3, 6, 10};
        new_game(8'h07);
        checks++;
        if (score !== 8'd0 || lives !== 4'd2 || round_idx !== 8'd0 || game_over !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_from_done: score=%0d lives=%0d round=%0d over=%b busy=%b, want 0 2 0 0 1",
                     score, lives, round_idx, game_over, busy);
        end
        for (int r = 0; r < 3; r++) begin
            wait_arm("hits");
            for (int c = 0; c < hit_at[r]; c++) tick();
            hit  = 1'b1;
            miss = (r == 0);
            push_exp(1'b1);
            tick();
            hit  = 1'b0;
            miss = 1'b0;
            checks++;
            if (led !== 8'h00 || lives !== 4'd2) begin
                errors++;
                $display("FAIL hit_round%0d: led=%h lives=%0d, want 00 2", r + 1, led, lives);
            end
        end
        checks++;
        if (game_over !== 1'b1 || score !== 8'd3 || round_idx !== 8'd3) begin
            errors++;
            $display("FAIL all_rounds_done: over=%b score=%0d round=%0d, want 1 3 3", game_over, score, round_idx);
        end
    endtask

    // Restart from DONE, then a start pulse inside GAP must not disturb pacing.
    task automatic test_restart();
        new_game(8'h00);
        checks++;
        if (score !== 8'd0 || lives !== 4'd2 || round_idx !== 8'd0 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL restart_clear: score=%0d lives=%0d round=%0d over=%b, want 0 2 0 0",
                     score, lives, round_idx, game_over);
        end
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checks++;
        if (freq !== 1'b1 || led !== 8'h01) begin
            errors++;
            $display("FAIL start_ignored_in_gap: freq=%b led=%h, want 1 01", freq, led);
        end
    endtask

`ifdef WHACK_SPEEDUP_EN
    logic       s_start = 1'b0;
    logic       s_hit = 1'b0;
    logic       s_freq;
    logic [7:0] s_led;
    logic [7:0] s_score;
    logic [3:0] s_lives;
    logic [7:0] s_round;
    logic       s_busy;
    logic       s_over;

    whack_round_ctrl #(
        .GAP_CYCLES(GAP), .WINDOW_CYCLES(80), .BLANK_CYCLES(BLANK),
        .ROUNDS(8), .LIVES(LIVES), .MIN_WINDOW(64)
    ) dut_s (
        .clk_i(clk), .rst_i(rst), .start_i(s_start), .random_i(8'h01),
        .hit_i(s_hit), .miss_i(1'b0), .freq_o(s_freq), .led_o(s_led),
        .score_o(s_score), .lives_o(s_lives), .round_idx_o(s_round),
        .busy_o(s_busy), .game_over_o(s_over)
    );

    // Hit, timeout, hit, hit, timeout: timeouts reveal the current window.
    task automatic test_speedup();
        bit pattern[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int w = 80;
        int n;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (int r = 0; r < 5; r++) begin
            n = 0;
            while (s_freq !== 1'b1 && n < 40) begin
                tick();
                n++;
            end
            tick();
            if (pattern[r]) begin
                tick();
                tick();
                s_hit = 1'b1;
                tick();
                s_hit = 1'b0;
                w = ((w - (w >> 3)) < 64) ? 64 : (w - (w >> 3));
            end else begin
                n = 0;
                while (s_led !== 8'h00 && n < 200) begin
                    n++;
                    tick();
                end
                checks++;
                if (n != w) begin
                    errors++;
                    $display("FAIL speedup_window_r%0d: wait_cycles=%0d, want %0d", r + 1, n, w);
                end
            end
        end
        checks++;
        if (s_over !== 1'b1 || s_score !== 8'd3 || s_lives !== 4'd0) begin
            errors++;
            $display("FAIL speedup_end: over=%b score=%0d lives=%0d, want 1 3 0", s_over, s_score, s_lives);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_start_timing();
        test_blank_hit();
        test_reset_mid_wait();
        test_timeout();
        test_hit_and_miss();
        test_restart();
`ifdef WHACK_SPEEDUP_EN
        test_speedup();
`endif
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expected resolutions never seen, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
